mem_arbiter: RTL and testbench

Two-requester arbiter that shares the single-port unified instruction/data memory of the multicycle RV32I system between the core (requester 0) and a loader/debug port (requester 1). It grants at most one memory access per cycle, using round-robin with an optional bounded lock for bursts. It steers the granted requester's address, data and write enable onto the memory and returns synchronous-read data to the owner of each read with a one-cycle valid pulse.

---
 rtl/mem_arbiter.sv | 136 +++++++++++++
 tb/tb_mem_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter for a single-port synchronous-read memory.
// Supports bounded lock bursts and routes each read result back to its owner one cycle later.
module mem_arbiter #(
  parameter int unsigned MAX_BURST = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        r0_req,
  input  logic [31:0] r0_addr,
  input  logic [31:0] r0_wr_data,
  input  logic        r0_wr_ena,
  input  logic        r0_lock,
  output logic        r0_gnt,
  output logic [31:0] r0_rd_data,
  output logic        r0_rd_valid,
  input  logic        r1_req,
  input  logic [31:0] r1_addr,
  input  logic [31:0] r1_wr_data,
  input  logic        r1_wr_ena,
  input  logic        r1_lock,
  output logic        r1_gnt,
  output logic [31:0] r1_rd_data,
  output logic        r1_rd_valid,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wr_data,
  output logic        mem_wr_ena,
  input  logic [31:0] mem_rd_data
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_e;

  localparam logic [7:0] BurstLimit = 8'(MAX_BURST);

  state_e      state_q, state_d;
  logic        last_winner_q, last_winner_d;
  logic [7:0]  burst_cnt_q, burst_cnt_d;
  logic        rd_pending_q, rd_pending_d;
  logic        rd_owner_q, rd_owner_d;
  logic [31:0] hold_addr_q, hold_addr_d;
  logic [31:0] hold_wr_data_q, hold_wr_data_d;

  logic        grant;
  logic        winner;
  logic        below_limit;
  logic        win_lock;
  logic        win_wr_ena;
  logic [31:0] win_addr;
  logic [31:0] win_wr_data;
  state_e      win_state;

  // Winner selection: a lock owner keeps the memory until its burst hits the limit
  // while the other side waits; otherwise plain round-robin on last_winner.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    grant       = 1'b0;
    winner      = 1'b0;
    below_limit = (burst_cnt_q < BurstLimit);
    if (state_q == OWN0 && r0_req && (below_limit || !r1_req)) begin
      grant  = 1'b1;
      winner = 1'b0;
    end else if (state_q == OWN1 && r1_req && (below_limit || !r0_req)) begin
      grant  = 1'b1;
      winner = 1'b1;
    end else if (r0_req && r1_req) begin
      grant  = 1'b1;
      winner = ~last_winner_q;
    end else if (r0_req || r1_req) begin
      grant  = 1'b1;
      winner = r1_req;
    end
    if (!rst) begin
      grant = 1'b0;
    end
  end

  assign win_lock    = winner ? r1_lock    : r0_lock;
  assign win_wr_ena  = winner ? r1_wr_ena  : r0_wr_ena;
  assign win_addr    = winner ? r1_addr    : r0_addr;
  assign win_wr_data = winner ? r1_wr_data : r0_wr_data;
  assign win_state   = winner ? OWN1 : OWN0;

  assign r0_gnt      = grant & ~winner;
  assign r1_gnt      = grant & winner;
  assign mem_wr_ena  = grant & win_wr_ena;
  assign mem_addr    = !rst ? '0 : (grant ? win_addr    : hold_addr_q);
  assign mem_wr_data = !rst ? '0 : (grant ? win_wr_data : hold_wr_data_q);

  // Next state: an ungranted cycle always drops ownership and clears the burst count.
  always_comb begin
    state_d        = IDLE;
    burst_cnt_d    = '0;
    last_winner_d  = last_winner_q;
    rd_pending_d   = grant & ~win_wr_ena;
    rd_owner_d     = grant ? winner : rd_owner_q;
    hold_addr_d    = grant ? win_addr : hold_addr_q;
    hold_wr_data_d = grant ? win_wr_data : hold_wr_data_q;
    if (grant) begin
      last_winner_d = winner;
      if (win_lock) begin
        state_d = win_state;
        if (state_q == win_state) begin
          burst_cnt_d = (burst_cnt_q == 8'hFF) ? 8'hFF : burst_cnt_q + 8'd1;
        end else begin
          burst_cnt_d = 8'd1;
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= IDLE;
      last_winner_q  <= 1'b1;
      burst_cnt_q    <= '0;
      rd_pending_q   <= 1'b0;
      rd_owner_q     <= 1'b0;
      hold_addr_q    <= '0;
      hold_wr_data_q <= '0;
    end else begin
      state_q        <= state_d;
      last_winner_q  <= last_winner_d;
      burst_cnt_q    <= burst_cnt_d;
      rd_pending_q   <= rd_pending_d;
      rd_owner_q     <= rd_owner_d;
      hold_addr_q    <= hold_addr_d;
      hold_wr_data_q <= hold_wr_data_d;
    end
  end

  assign r0_rd_valid = rst & rd_pending_q & ~rd_owner_q;
  assign r1_rd_valid = rst & rd_pending_q & rd_owner_q;
  assign r0_rd_data  = r0_rd_valid ? mem_rd_data : '0;
  assign r1_rd_data  = r1_rd_valid ? mem_rd_data : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus random traffic, a behavioural
// arbitration/memory model, and a scoreboard monitor for read returns.
module tb_mem_arbiter;

  localparam int MAX_BURST = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req, wr, lock;
  logic [31:0] addr [2];
  logic [31:0] wdata[2];
  logic        r0_gnt, r1_gnt, r0_rd_valid, r1_rd_valid;
  logic [31:0] r0_rd_data, r1_rd_data;
  logic [31:0] mem_addr, mem_wr_data, mem_rd_data;
  logic        mem_wr_ena;

  mem_arbiter #(.MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .rst(rst),
    .r0_req(req[0]), .r0_addr(addr[0]), .r0_wr_data(wdata[0]), .r0_wr_ena(wr[0]),
    .r0_lock(lock[0]), .r0_gnt(r0_gnt), .r0_rd_data(r0_rd_data), .r0_rd_valid(r0_rd_valid),
    .r1_req(req[1]), .r1_addr(addr[1]), .r1_wr_data(wdata[1]), .r1_wr_ena(wr[1]),
    .r1_lock(lock[1]), .r1_gnt(r1_gnt), .r1_rd_data(r1_rd_data), .r1_rd_valid(r1_rd_valid),
    .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_wr_ena(mem_wr_ena),
    .mem_rd_data(mem_rd_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] init_val(int i);
    return 32'hA500_0000 ^ (i * 32'h0001_0203);
  endfunction

  // Physical memory seen by the DUT: synchronous read, write commits on the edge.
  logic [31:0] mem [64];
  logic        mem_init = 1'b0;
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_val(i);
      mem_init <= 1'b1;
    end else begin
      if (mem_wr_ena) mem[mem_addr[7:2]] <= mem_wr_data;
      mem_rd_data <= mem[mem_addr[7:2]];
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(string name, logic [127:0] act, logic [127:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, want);
    end
  endtask

  // Reference model: owner (2 = nobody), last winner, run length of the current burst.
  int          m_owner, m_last, m_run;
  logic [31:0] m_addr, m_wdata;
  logic [31:0] ref_mem [64];
  int          last_w = 2;
  int          gseq[$];

  typedef struct {
    int          owner;
    logic [31:0] data;
    int          due;
  } rd_exp_t;
  rd_exp_t sb[$];
  rd_exp_t e;

  function automatic int pick();
    if (m_owner != 2 && req[m_owner] && (m_run < MAX_BURST || !req[1 - m_owner]))
      return m_owner;
    if (req[0] && req[1]) return 1 - m_last;
    if (req[0]) return 0;
    if (req[1]) return 1;
    return 2;
  endfunction

  // One bus cycle: predict and compare at negedge, advance the model at posedge.
  task automatic cycle();
    int w;
    logic [66:0] want;
    @(negedge clk);
    if (!rst) begin
      w    = 2;
      want = '0;
    end else begin
      w = pick();
      if (w != 2) begin
        want = {w == 0, w == 1, wr[w], addr[w], wdata[w]};
        if (!wr[w]) sb.push_back('{w, ref_mem[addr[w][7:2]], cyc + 1});
      end else begin
        want = {3'b000, m_addr, m_wdata};
      end
    end
    check("bus", {r0_gnt, r1_gnt, mem_wr_ena, mem_addr, mem_wr_data}, want);
    gseq.push_back(r0_gnt ? 0 : (r1_gnt ? 1 : 2));
    last_w = w;
    @(posedge clk);
    if (!rst) begin
      m_owner = 2; m_last = 1; m_run = 0; m_addr = '0; m_wdata = '0;
    end else if (w != 2) begin
      if (wr[w]) ref_mem[addr[w][7:2]] = wdata[w];
      m_addr  = addr[w];
      m_wdata = wdata[w];
      m_last  = w;
      if (lock[w]) begin
        m_run   = (m_owner == w) ? ((m_run < 255) ? m_run + 1 : 255) : 1;
        m_owner = w;
      end else begin
        m_owner = 2;
        m_run   = 0;
      end
    end else begin
      m_owner = 2;
      m_run   = 0;
    end
    #1;
  endtask

  // Read-return monitor: every valid must match the oldest prediction due this cycle.
  always @(negedge clk) begin
    if (r0_rd_valid || r1_rd_valid) begin
      if (sb.size() == 0 || sb[0].due != cyc) begin
        check("unexpected_rd_valid", {r1_rd_valid, r0_rd_valid}, 2'b00);
      end else begin
        e = sb.pop_front();
        check("rd_valid", {r1_rd_valid, r0_rd_valid}, (e.owner == 1) ? 2'b10 : 2'b01);
        check("rd_data", {r1_rd_data, r0_rd_data},
              (e.owner == 1) ? {e.data, 32'h0} : {32'h0, e.data});
      end
    end else if (sb.size() != 0 && sb[0].due == cyc) begin
      check("missing_rd_valid", {r1_rd_valid, r0_rd_valid}, (sb[0].owner == 1) ? 2'b10 : 2'b01);
      void'(sb.pop_front());
    end
  end

  task automatic set_req(int n, logic rq, logic [31:0] a, logic we, logic [31:0] wd, logic lk);
    req[n]   = rq;
    addr[n]  = a;
    wr[n]    = we;
    wdata[n] = wd;
    lock[n]  = lk;
  endtask

  task automatic expect_seq(string name, int want[$]);
    check({name, "_len"}, gseq.size(), want.size());
    foreach (want[i]) if (i < gseq.size()) check(name, gseq[i], want[i]);
    gseq.delete();
  endtask

  task automatic new_txn(int n);
    set_req(n, $urandom_range(0, 3) != 0, {26'h0, 4'($urandom_range(0, 15)), 2'b00},
            $urandom_range(0, 2) == 0, $urandom, 1'($urandom_range(0, 1)));
  endtask

  int want[$];

  initial begin
    for (int i = 0; i < 64; i++) ref_mem[i] = init_val(i);
    m_owner = 2; m_last = 1; m_run = 0; m_addr = '0; m_wdata = '0;

    // Reset with both requesting, then round-robin ties.
    rst = 1'b0;
    set_req(0, 1'b1, 32'h00, 1'b0, 32'h0, 1'b0);
    set_req(1, 1'b1, 32'h04, 1'b0, 32'h0, 1'b0);
    cycle(); cycle();
    gseq.delete();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) cycle();
    want = '{0, 1, 0, 1};
    expect_seq("tie_rr", want);

    // Burst limit: r1 locks, r0 joins from the third cycle.
    set_req(0, 1'b0, 32'h24, 1'b0, 32'h0, 1'b0);
    set_req(1, 1'b0, 32'h20, 1'b0, 32'h0, 1'b0);
    cycle();
    gseq.delete();
    set_req(1, 1'b1, 32'h20, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      if (i == 2) req[0] = 1'b1;
      cycle();
    end
    want.delete();
    for (int i = 0; i < 8; i++) want.push_back(1);
    want.push_back(0);
    for (int i = 0; i < 8; i++) want.push_back(1);
    want.push_back(0); want.push_back(1); want.push_back(1);
    expect_seq("burst", want);

    // Write/read ordering with last_winner = 0.
    set_req(1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    set_req(0, 1'b1, 32'h30, 1'b0, 32'h0, 1'b0);
    cycle();
    set_req(0, 1'b1, 32'h10, 1'b0, 32'h0, 1'b0);
    set_req(1, 1'b1, 32'h10, 1'b1, 32'hDEAD_BEEF, 1'b0);
    cycle();
    req[1] = 1'b0;
    cycle();
    check("wr_then_rd_model", ref_mem[4], 32'hDEAD_BEEF);
    want = '{0, 1, 0};
    expect_seq("wr_rd_order", want);

    // Lock release: r0 locks for 3 grants, drops req while r1 waits.
    set_req(0, 1'b1, 32'h08, 1'b0, 32'h0, 1'b1);
    cycle(); cycle();
    set_req(1, 1'b1, 32'h0C, 1'b0, 32'h0, 1'b0);
    cycle();
    req[0] = 1'b0;
    cycle();
    want = '{0, 0, 0, 1};
    expect_seq("lock_release", want);

    // Reset right after a granted read drops its valid.
    set_req(0, 1'b1, 32'h08, 1'b0, 32'h0, 1'b0);
    req[1] = 1'b0;
    cycle();
    rst = 1'b0;
    sb.delete();
    req = 2'b00;
    cycle();
    gseq.delete();
    rst = 1'b1;
    req = 2'b11;
    lock = 2'b00;
    wr = 2'b00;
    cycle();
    want = '{0};
    expect_seq("post_reset_tie", want);

    // Random traffic with occasional resets.
    for (int n = 0; n < 2; n++) new_txn(n);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        rst = 1'b0;
        sb.delete();
      end else begin
        rst = 1'b1;
      end
      cycle();
      for (int n = 0; n < 2; n++) if (!req[n] || last_w == n) new_txn(n);
    end
    gseq.delete();
    rst = 1'b1;
    req = 2'b00;
    for (int i = 0; i < 3; i++) cycle();
    check("scoreboard_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
